// File: rtl/iir_pkg.sv
// Shared types for the IIR second-order-section scheduler.
package iir_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} sched_state_t;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/iir_sched_inbuf.sv
// One-deep pending-sample register for the IIR scheduler.
module iir_sched_inbuf #(
  parameter int Nd = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [Nd-1:0] d,
  output logic          full,
  output logic [Nd-1:0] q,
  output logic          drop
);
  // A push into a full buffer is only accepted when the held sample leaves this cycle.
  assign drop = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (push && (!full || pop)) begin
      full <= 1'b1;
      q    <= d;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/iir_sos_scheduler.sv
// Time-multiplexes one biquad datapath across Nsos cascaded sections,
// with one-deep input buffering, overrun accounting and a per-section watchdog.
module iir_sos_scheduler
  import iir_pkg::*;
#(
  parameter int Nsos    = 6,
  parameter int Nd      = 18,
  parameter int TIMEOUT = 64,
  localparam int SW     = (Nsos > 1) ? $clog2(Nsos) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dv_in,
  input  logic [Nd-1:0]         d_in,
  output logic                  dv_out,
  output logic [Nd-1:0]         d_out,
  output logic                  sec_start,
  output logic [SW-1:0]         sec_idx,
  output logic [Nd-1:0]         sec_x,
  input  logic                  sec_done,
  input  logic [Nd-1:0]         sec_y,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  flag_clr
);
  localparam int WW = $clog2(TIMEOUT + 1);

  sched_state_t  state, nstate;
  logic [SW-1:0] sec;
  logic [Nd-1:0] cur;
  logic [WW-1:0] wd;
  logic          last, abort, hand_off, bypass, push, pop;
  logic          pend_full, drop;
  logic [Nd-1:0] pend_q;

  assign last     = (sec == SW'(Nsos - 1));
  assign abort    = (state == WAIT) && !sec_done && (wd == WW'(TIMEOUT - 1));
  // hand_off: the cycle in which the current sample retires (output or abort)
  assign hand_off = (state == OUTPUT) || abort;
  // With the buffer empty at hand-off, a new sample goes straight into cur.
  assign bypass   = hand_off && !pend_full && dv_in;
  assign push     = dv_in && (state != IDLE) && !bypass;
  assign pop      = hand_off && pend_full;

  iir_sched_inbuf #(.Nd(Nd)) u_inbuf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .d    (d_in),
    .full (pend_full),
    .q    (pend_q),
    .drop (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:   if (dv_in) nstate = ISSUE;
      ISSUE:  nstate = WAIT;
      WAIT: begin
        if (sec_done)   nstate = last ? OUTPUT : ISSUE;
        else if (abort) nstate = (pend_full || dv_in) ? ISSUE : IDLE;
      end
      OUTPUT: nstate = (pend_full || dv_in) ? ISSUE : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec   <= '0;
      cur   <= '0;
      wd    <= '0;
      d_out <= '0;
    end else begin
      case (state)
        IDLE: if (dv_in) begin
          cur <= d_in;
          sec <= '0;
        end
        ISSUE: wd <= '0;
        WAIT: begin
          if (sec_done) begin
            cur <= sec_y;
            if (last) d_out <= sec_y;
            else      sec   <= sec + SW'(1);
          end else begin
            wd <= wd + WW'(1);
            if (abort) begin
              sec <= '0;
              if (pop)         cur <= pend_q;
              else if (bypass) cur <= d_in;
              else             cur <= '0;
            end
          end
        end
        OUTPUT: begin
          sec <= '0;
          if (pop)         cur <= pend_q;
          else if (bypass) cur <= d_in;
        end
        default: ;
      endcase
    end
  end

  // Drop and abort take priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)          overrun <= 1'b1;
      else if (flag_clr) overrun <= 1'b0;
      if (abort)         timeout <= 1'b1;
      else if (flag_clr) timeout <= 1'b0;
      if (drop) begin
        if (flag_clr)            drop_cnt <= DROP_CNT_W'(1);
        else if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end else if (flag_clr) begin
        drop_cnt <= '0;
      end
    end
  end

  assign sec_start = (state == ISSUE);
  assign dv_out    = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign sec_idx   = sec;
  assign sec_x     = cur;
endmodule

// File: tb/tb_iir_sos_scheduler.sv
// Directed bench for iir_sos_scheduler with a fixed-latency biquad model (y = x + idx + 1, L = 3).
module tb_iir_sos_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        dv_in = 1'b0, sec_done = 1'b0, flag_clr = 1'b0;
  logic [17:0] d_in = '0, sec_y = '0;
  logic        dv_out, sec_start, busy, overrun, timeout;
  logic [17:0] d_out, sec_x;
  logic [2:0]  sec_idx;
  logic [15:0] drop_cnt;

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, hold_idx = -1, cnt = 0;
  logic [17:0] x_cap;
  logic [2:0]  i_cap;
  int out_cyc[$], st_cyc[$], st_idx[$];
  logic [17:0] out_val[$];

  iir_sos_scheduler #(.Nsos(6), .Nd(18), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .d_in(d_in), .dv_out(dv_out), .d_out(d_out),
    .sec_start(sec_start), .sec_idx(sec_idx), .sec_x(sec_x), .sec_done(sec_done), .sec_y(sec_y),
    .busy(busy), .overrun(overrun), .timeout(timeout), .drop_cnt(drop_cnt), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Datapath model: sec_done is high for the whole cycle start+3.
  always @(negedge clk) begin
    sec_done = 1'b0;
    if (!rst_n) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && int'(i_cap) != hold_idx) begin
          sec_done = 1'b1;
          sec_y    = x_cap + 18'(i_cap) + 18'd1;
        end
      end
      if (sec_start) begin
        cnt = 3; x_cap = sec_x; i_cap = sec_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (dv_out) begin out_cyc.push_back(cyc); out_val.push_back(d_out); end
    if (sec_start) begin st_cyc.push_back(cyc); st_idx.push_back(int'(sec_idx)); end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    out_cyc.delete(); out_val.delete(); st_cyc.delete(); st_idx.delete();
  endtask

  task automatic send(input logic [17:0] d);
    dv_in = 1'b1; d_in = d; t0 = cyc;
    tick(1);
    dv_in = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({busy, dv_out, sec_start, overrun, timeout} !== 5'b0 || sec_idx !== 3'd0 ||
        sec_x !== 18'd0 || d_out !== 18'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: busy=%b dv_out=%b start=%b ovr=%b to=%b idx=%0d x=%h dout=%h cnt=%0d, required all 0",
               tag, busy, dv_out, sec_start, overrun, timeout, sec_idx, sec_x, d_out, drop_cnt);
    end
  endtask

  task automatic test_reset();
    tick(2);
    check_idle_zero("reset_state");
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    clear_logs();
    send(18'h00100);
    tick(24);
    checks++;
    if (dv_out !== 1'b1 || d_out !== 18'h00115 || busy !== 1'b1) begin
      errors++; $display("FAIL single_out: dv_out=%b d_out=%h busy=%b, required 1 00115 1", dv_out, d_out, busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || dv_out !== 1'b0 || d_out !== 18'h00115) begin
      errors++; $display("FAIL single_after: busy=%b dv_out=%b d_out=%h, required 0 0 00115", busy, dv_out, d_out);
    end
    tick(5);
    checks++;
    if (st_cyc.size() != 6) begin
      errors++; $display("FAIL single_starts: count %0d, required 6", st_cyc.size());
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (st_cyc[i] - t0 != 1 + 4 * i || st_idx[i] != i) begin
          errors++; $display("FAIL single_start%0d: cycle %0d idx %0d, required %0d idx %0d",
                             i, st_cyc[i] - t0, st_idx[i], 1 + 4 * i, i);
        end
      end
    checks++;
    if (out_cyc.size() != 1 || out_cyc[0] - t0 != 25) begin
      errors++; $display("FAIL single_latency: pulses %0d, required 1 at cycle 25", out_cyc.size());
    end
  endtask

  task automatic test_pending();
    int b;
    clear_logs();
    send(18'h00100); b = t0;
    tick(6);
    send(18'h00200);
    tick(50);
    checks++;
    if (out_cyc.size() != 2) begin
      errors++; $display("FAIL pending_count: %0d pulses, required 2", out_cyc.size());
    end else begin
      checks++;
      if (out_cyc[0] - b != 25 || out_cyc[1] - b != 50 || out_val[0] !== 18'h00115 || out_val[1] !== 18'h00215) begin
        errors++; $display("FAIL pending_out: cycles %0d,%0d vals %h,%h, required 25,50 00115,00215",
                           out_cyc[0] - b, out_cyc[1] - b, out_val[0], out_val[1]);
      end
    end
    checks++;
    if (st_cyc.size() < 7 || st_cyc[6] - b != 26 || st_idx[6] != 0) begin
      errors++; $display("FAIL pending_issue: second sample not issued at cycle 26 with idx 0");
    end
    checks++;
    if (overrun !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL pending_flags: overrun=%b drop_cnt=%0d, required 0 0", overrun, drop_cnt);
    end
  endtask

  task automatic test_drop();
    clear_logs();
    send(18'h00100);
    tick(6);
    send(18'h00200);
    tick(6);
    send(18'h00300);
    tick(55);
    checks++;
    if (out_val.size() != 2 || out_val[0] !== 18'h00115 || out_val[1] !== 18'h00215) begin
      errors++; $display("FAIL drop_outputs: %0d pulses, required 2 (00115, 00215)", out_val.size());
    end
    checks++;
    if (overrun !== 1'b1 || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL drop_flags: overrun=%b drop_cnt=%0d, required 1 1", overrun, drop_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    hold_idx = 2;
    send(18'h00100);
    tick(24);
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early: busy=%b timeout=%b, required 1 0", busy, timeout);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: busy=%b timeout=%b, required 0 1", busy, timeout);
    end
    tick(10);
    checks++;
    if (out_cyc.size() != 0) begin
      errors++; $display("FAIL timeout_no_out: %0d pulses, required 0", out_cyc.size());
    end
    hold_idx = -1;
    send(18'h00000);
    tick(30);
    checks++;
    if (out_cyc.size() != 1 || out_cyc[0] - t0 != 25 || out_val[0] !== 18'h00015) begin
      errors++; $display("FAIL timeout_recover: %0d pulses, required 1 at cycle 25 with 00015", out_cyc.size());
    end
  endtask

  task automatic test_flag_clr();
    clear_logs();
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || timeout !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_alone: ovr=%b to=%b cnt=%0d, required 0 0 0", overrun, timeout, drop_cnt);
    end
    dv_in = 1'b1; d_in = 18'h00100; t0 = cyc;
    tick(7);
    checks++;
    if (drop_cnt !== 16'd5 || overrun !== 1'b1) begin
      errors++; $display("FAIL clr_pre: drop_cnt=%0d overrun=%b, required 5 1", drop_cnt, overrun);
    end
    flag_clr = 1'b1;
    tick(1);
    dv_in = 1'b0; flag_clr = 1'b0;
    checks++;
    if (drop_cnt !== 16'd1 || overrun !== 1'b1) begin
      errors++; $display("FAIL clr_vs_drop: drop_cnt=%0d overrun=%b, required 1 1", drop_cnt, overrun);
    end
    tick(60);
    checks++;
    if (out_cyc.size() != 2) begin
      errors++; $display("FAIL clr_outputs: %0d pulses, required 2", out_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send(18'h00100);
    tick(6);
    send(18'h00200);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    tick(2);
    rst_n = 1'b1;
    tick(60);
    checks++;
    if (out_cyc.size() != 0) begin
      errors++; $display("FAIL reset_no_out: %0d pulses, required 0", out_cyc.size());
    end
    send(18'h00040);
    tick(30);
    checks++;
    if (out_cyc.size() != 1 || out_cyc[0] - t0 != 25 || out_val[0] !== 18'h00055) begin
      errors++; $display("FAIL reset_fresh: %0d pulses, required 1 at cycle 25 with 00055", out_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_drop();
    test_timeout();
    test_flag_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_sos_scheduler.md
Name: iir_sos_scheduler

Overview:
Time-multiplexes one shared biquad (second-order-section) arithmetic unit across all Nsos sections of the cascaded IIR filter. Per accepted input sample it issues Nsos section requests in order (0..Nsos-1) and feeds each section's result into the next. After the last section it emits the filter output. It sits between the sample strobe source (dv_in/d_in) and the biquad datapath, and provides one-deep input buffering, overrun accounting and a datapath watchdog.

Parameters:
Nsos, 6, number of cascaded sections; index width SW = max(1,$clog2(Nsos))
Nd, 18, sample width (signed two's complement)
TIMEOUT, 64, max WAIT cycles per section before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
dv_in  in  1  input sample strobe, single-cycle
d_in  in  Nd  input sample, valid with dv_in
dv_out  out  1  output sample strobe, single-cycle
d_out  out  Nd  filter output, valid with dv_out, held until next dv_out
sec_start  out  1  one-cycle request to biquad datapath
sec_idx  out  SW  section index, selects coefficient/state bank; stable from sec_start until done/abort
sec_x  out  Nd  section input; stable while sec_idx stable
sec_done  in  1  datapath result strobe; sampled only in WAIT
sec_y  in  Nd  section result, valid with sec_done
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: an input sample was dropped
timeout  out  1  sticky: watchdog abort occurred
drop_cnt  out  16  dropped-sample count, saturates at 16'hFFFF
flag_clr  in  1  clears overrun, timeout, drop_cnt

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; pending buffer empty; watchdog counter 0.
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: dv_in -> latch d_in as cur, sec=0, go ISSUE. No dv_in -> stay.
- ISSUE: sec_start=1 for exactly this cycle; sec_idx=sec; sec_x=cur. Go WAIT, watchdog=0.
- WAIT: sec_done=1 -> cur<=sec_y. If sec==Nsos-1 go OUTPUT, else sec++ and go ISSUE. sec_done=0 -> watchdog++. On the TIMEOUT-th WAIT cycle without done: set timeout, discard cur, no dv_out. Then go ISSUE with pending (sec=0) if pending valid, else IDLE.
- OUTPUT: dv_out=1 and d_out=cur this cycle. If pending valid: cur<=pending, pending cleared, sec=0, go ISSUE. Else go IDLE.
- Latency with datapath delay L (done L cycles after start): dv_in in cycle 0 -> dv_out in cycle Nsos*(L+1)+1. A pending sample's dv_out follows the previous dv_out by Nsos*(L+1)+1 cycles.
- Input while busy: pending empty (or being consumed this cycle) -> store in pending. Pending full and not consumed -> drop, overrun<=1, drop_cnt++ (saturating).
- sec_done outside WAIT: ignored, no effect.
- flag_clr and a drop in the same cycle: the drop wins (overrun=1, drop_cnt=1). flag_clr and a timeout in the same cycle: timeout=1.
- No arithmetic on samples; sec_y passes through unmodified at full Nd width.
- Reset mid-operation: sample in flight and pending both lost. No dv_out is generated afterwards.

Decomposition:
- Package iir_pkg: typedef enum logic[1:0] {IDLE, ISSUE, WAIT, OUTPUT} sched_state_t; localparam DROP_CNT_W = 16.
- Sub-module iir_sched_inbuf: one-deep pending register with push/pop/full and drop-detect outputs. Counter and flags stay in the top level.

Test Plan:
Bench model datapath: sec_y = sec_x + sec_idx + 1, L=3; Nsos=6, TIMEOUT=16.
- Single sample d_in=18'h00100 at cycle 0 -> sec_start at cycles 1,5,9,13,17,21 with sec_idx 0..5; dv_out at cycle 25 with d_out=18'h00115; busy low from cycle 26.
- Samples at cycles 0 and 7 -> second sample held pending and issued at cycle 26; outputs at cycles 25 and 50; overrun=0.
- Samples at cycles 0, 7, 14 -> third dropped; overrun=1, drop_cnt=1; exactly two dv_out pulses.
- Model withholds sec_done for sec_idx=2 -> timeout=1 after 16 WAIT cycles, no dv_out. Next sample d_in=0 gives d_out=18'h00015.
- rst_n low at cycle 10 with a pending sample -> all outputs 0 immediately, no later dv_out; a fresh sample after release gives normal 25-cycle latency.
- flag_clr pulsed in the same cycle as a drop, with drop_cnt=5 -> drop_cnt=1, overrun=1. flag_clr alone -> all flags and count 0.
